// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the LEGv8 fetch front-end controller.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [4:0] XZR       = 5'd31;
    localparam int         FLUSH_MAX = 3;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Pipeline-side signal bundle of fetch_ctrl: hazard/branch inputs in, IF/ID control and counters out.
interface fetch_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs2;
    logic             ex_memread;
    logic [4:0]       ex_rd;
    logic             br_taken;
    logic             halt_req;
    logic             resume;
    logic             PC_select;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        input  id_rs1, id_rs2, id_uses_rs2, ex_memread, ex_rd,
               br_taken, halt_req, resume,
        output PC_select, pc_we, ifid_we, ifid_flush, idex_bubble,
               halted, stall_cnt, flush_cnt
    );

    modport slave (
        output id_rs1, id_rs2, id_uses_rs2, ex_memread, ex_rd,
               br_taken, halt_req, resume,
        input  PC_select, pc_we, ifid_we, ifid_flush, idex_bubble,
               halted, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/fetch_ctrl_hazard_detect.sv
// Load-use hazard equation; combinational so the forwarding unit can reuse it.
module hazard_detect
    import fetch_ctrl_pkg::*;
(
    input  logic       ex_memread_i,
    input  logic [4:0] ex_rd_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_uses_rs2_i,
    output logic       hazard_o
);

    // XZR never carries a real result, so a load into it cannot create a dependency.
    assign hazard_o = ex_memread_i && (ex_rd_i != XZR) &&
                      ((ex_rd_i == id_rs1_i) || (id_uses_rs2_i && (ex_rd_i == id_rs2_i)));

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch front-end controller: load-use stalls, branch squash, HALT parking and perf counters.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic          clk,
    input  logic          reset,
    fetch_ctrl_if.master  bus
);

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > FLUSH_MAX) begin : g_bad_flush_cycles
        $error("fetch_ctrl: FLUSH_CYCLES out of range 1..3");
    end

    localparam logic [1:0] REM_INIT = 2'(FLUSH_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       rem_q, rem_d;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             stall_inc, flush_inc;
    logic             hazard;

    hazard_detect u_hazard (
        .ex_memread_i  (bus.ex_memread),
        .ex_rd_i       (bus.ex_rd),
        .id_rs1_i      (bus.id_rs1),
        .id_rs2_i      (bus.id_rs2),
        .id_uses_rs2_i (bus.id_uses_rs2),
        .hazard_o      (hazard)
    );

    always_comb begin
        state_d         = state_q;
        rem_d           = rem_q;
        stall_inc       = 1'b0;
        flush_inc       = 1'b0;
        bus.PC_select   = 1'b0;
        bus.pc_we       = 1'b1;
        bus.ifid_we     = 1'b1;
        bus.ifid_flush  = 1'b0;
        bus.idex_bubble = 1'b0;
        bus.halted      = 1'b0;
        case (state_q)
            RUN: begin
                // A taken branch wins: ID holds a wrong-path instruction, so its halt/hazard is moot.
                if (bus.br_taken) begin
                    bus.PC_select   = 1'b1;
                    bus.ifid_flush  = 1'b1;
                    bus.idex_bubble = 1'b1;
                    flush_inc       = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        rem_d   = REM_INIT;
                    end
                end else if (bus.halt_req) begin
                    bus.pc_we       = 1'b0;
                    bus.ifid_we     = 1'b0;
                    bus.idex_bubble = 1'b1;
                    state_d         = HALT;
                end else if (hazard) begin
                    bus.pc_we       = 1'b0;
                    bus.ifid_we     = 1'b0;
                    bus.idex_bubble = 1'b1;
                    stall_inc       = 1'b1;
                end
            end
            FLUSH: begin
                bus.ifid_flush = 1'b1;
                rem_d          = rem_q - 2'd1;
                if (rem_q == 2'd1) state_d = RUN;
            end
            HALT: begin
                bus.pc_we       = 1'b0;
                bus.ifid_we     = 1'b0;
                bus.idex_bubble = 1'b1;
                bus.halted      = 1'b1;
                // Resume flushes the parked HALT out of IF/ID while fetch restarts.
                if (bus.resume) begin
                    bus.pc_we      = 1'b1;
                    bus.ifid_flush = 1'b1;
                    state_d        = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        if (reset) begin
            bus.PC_select   = 1'b0;
            bus.pc_we       = 1'b1;
            bus.ifid_we     = 1'b1;
            bus.ifid_flush  = 1'b0;
            bus.idex_bubble = 1'b0;
            bus.halted      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            rem_q   <= 2'd0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            if (stall_inc) stall_q <= stall_q + CNT_W'(1);
            if (flush_inc) flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Pipeline front-end controller for the LEGv8 5-stage CPU.
- Drives the IF stage's PC_select and PC write enable, and the IF/ID register enable and flush.
- Inserts the ID/EX bubble for load-use hazards, squashes wrong-path fetches after taken branches, and parks fetch on HALT.
- Keeps stall and flush performance counters for the testbench and the debug readout.

Parameters:
- FLUSH_CYCLES, 1: IF/ID flush cycles per taken branch, including the redirect cycle. Legal range 1..3.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- id_rs1  in  5  Rn of the instruction in ID
- id_rs2  in  5  Rm or Rt of the instruction in ID
- id_uses_rs2  in  1  ID instruction reads id_rs2
- ex_memread  in  1  EX instruction is a load
- ex_rd  in  5  destination register of the EX instruction
- br_taken  in  1  the branch resolved in EX is taken
- halt_req  in  1  ID holds a HALT instruction
- resume  in  1  leave HALT
- PC_select  out  1  1 = branch target, 0 = PC+4; feeds IF directly
- pc_we  out  1  PC register write enable
- ifid_we  out  1  IF/ID register write enable
- ifid_flush  out  1  load a NOP into IF/ID at the next edge
- idex_bubble  out  1  zero the control bits entering ID/EX
- halted  out  1  state == HALT
- stall_cnt  out  CNT_W  load-use stall cycles since reset
- flush_cnt  out  CNT_W  taken-branch redirects since reset

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high, ports named clk and reset.
- Reset values:
  - state = RUN, flush counter = 0, stall_cnt = 0, flush_cnt = 0.
  - Outputs while reset is asserted: PC_select=0, pc_we=1, ifid_we=1, ifid_flush=0, idex_bubble=0, halted=0.
- States: RUN, FLUSH, HALT.
- Outputs are Mealy, combinational from state and inputs, so stalls and redirects take effect in the same cycle. State and counters update on the rising clk edge.
- hazard = ex_memread && ex_rd != XZR(31) && (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2)).
- Priority in RUN: br_taken > halt_req > hazard > normal.
- RUN, normal: PC_select=0, pc_we=1, ifid_we=1, ifid_flush=0, idex_bubble=0.
- RUN, br_taken:
  - PC_select=1, pc_we=1, ifid_flush=1, idex_bubble=1 (kills the ID wrong-path instruction); flush_cnt += 1.
  - If FLUSH_CYCLES > 1: go to FLUSH with remaining = FLUSH_CYCLES-1. Otherwise stay in RUN.
  - A concurrent halt_req or hazard is ignored, because ID holds a wrong-path instruction.
- RUN, halt_req (no branch): pc_we=0, ifid_we=0, idex_bubble=1; go to HALT. The HALT instruction stays parked in IF/ID.
- RUN, hazard (no branch, no halt): pc_we=0, ifid_we=0, idex_bubble=1; stall_cnt += 1.
  - The next cycle re-evaluates. The load has left EX, so a stall is exactly one cycle.
- FLUSH: PC_select=0, pc_we=1, ifid_flush=1, idex_bubble=0. Decrement remaining; return to RUN when it reaches 0. Hazard and halt are ignored in this state.
- HALT:
  - pc_we=0, ifid_we=0, idex_bubble=1, halted=1.
  - On resume: pc_we=1, ifid_flush=1 (consumes the HALT), return to RUN.
  - br_taken in HALT cannot occur because EX holds bubbles; it is ignored.
- Counters wrap modulo 2^CNT_W and are never saturated.
- Reset mid-FLUSH or mid-HALT returns immediately to RUN with the reset values above.

Decomposition:
- Shared package fetch_ctrl_pkg:
  - state typedef enum logic [1:0] {RUN, FLUSH, HALT};
  - constant XZR = 5'd31;
  - constant FLUSH_MAX = 3.
- Sub-module hazard_detect: purely combinational hazard equation, reused later by the forwarding unit.

Test Plan:
- Reset pulse mid-HALT → halted=0, pc_we=1, counters=0 immediately, before the next clk edge.
- Load-use: ex_memread=1, ex_rd=3, id_rs1=3 for one cycle → pc_we=0, ifid_we=0, idex_bubble=1 for exactly 1 cycle; stall_cnt=1.
- XZR and unused rs2:
  - ex_rd=31=id_rs1 → no stall.
  - ex_rd=5=id_rs2 with id_uses_rs2=0 → no stall.
  - Same with id_uses_rs2=1 → stall.
- Taken branch, FLUSH_CYCLES=1 then 3:
  - PC_select=1 for 1 cycle.
  - ifid_flush high 1 and 3 consecutive cycles respectively.
  - flush_cnt increments by 1 each time.
- br_taken, halt_req and hazard in the same cycle → redirect only: halted stays 0, stall_cnt unchanged.
- halt_req → HALT with PC frozen for 10 cycles; resume → ifid_flush=1 for one cycle, then normal fetch with pc_we=1.
